// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller that time-shares one external
// combinational full adder, one bit per clock, LSB first.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   S_IDLE | waiting for operands; in_ready high, adder inputs held at 0
//   S_RUN  | one bit per cycle through the shared adder, WIDTH cycles total
//   S_DONE | result presented with out_valid high until out_ready
//
// The carry between bits lives in r_carry. The carry into the MSB is latched
// in r_msb_cin on the last RUN cycle so signed overflow is one XOR in DONE.
// Result outputs are forced to 0 outside DONE, so a partial sum is never
// visible and an asynchronous reset clears every output at once.
module serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_r,
   input  logic             fa_cout
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_last;

   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic               r_carry;
   logic               r_msb_cin;
   logic [CNT_W-1:0]   r_cnt;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus all handshake, adder-drive and result outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      sum         = '0;
      cout        = 1'b0;
      ovf         = 1'b0;
      fa_a        = 1'b0;
      fa_b        = 1'b0;
      fa_cin      = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            fa_a   = r_a_sh[0];
            fa_b   = r_b_sh[0];
            fa_cin = r_carry;
            if (r_cnt == CNT_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            sum       = r_sum_sh;
            cout      = r_carry;
            ovf       = r_msb_cin ^ r_carry;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Operand load on accept, then one shift/accumulate step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_sum_sh  <= '0;
         r_carry   <= 1'b0;
         r_msb_cin <= 1'b0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_a_sh  <= a;
         r_b_sh  <= b;
         r_carry <= cin;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_sum_sh <= {fa_r, r_sum_sh[WIDTH-1:1]};
         r_carry  <= fa_cout;
         r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
         r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_msb_cin <= r_carry;
         end
      end
   end

endmodule
